// File: rtl/adder_seq_arbiter.sv
// Round-robin arbiter sharing one external SLICE-bit adder between two
// requesters; a WIDTH-bit sum is built LSB-slice first over NSLICE cycles.
module adder_seq_arbiter #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    input  logic [SLICE-1:0] add_sum,
    input  logic             add_cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, result_work, sum_full;
    logic [IW-1:0]    idx;
    logic             carry, id_reg, last_gnt, grant_any, last_slice;

    // Arbitration: grants only in IDLE; on contention favour the requester
    // not granted most recently (last_gnt=1 after reset favours req0).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign grant_any  = gnt0 | gnt1;
    assign last_slice = (idx == IW'(NSLICE - 1));
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: IDLE -> RUN on grant, RUN for NSLICE cycles, DONE for one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slice operand mux and the full-width sum with the current slice merged in.
    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        sum_full = result_work;
        sum_full[int'(idx)*SLICE +: SLICE] = add_sum;
        if (state == RUN) begin
            add_a   = a_reg[int'(idx)*SLICE +: SLICE];
            add_b   = b_reg[int'(idx)*SLICE +: SLICE];
            add_cin = carry;
        end
    end

    // Operand capture, per-slice accumulation and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            result_work <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            id_reg      <= 1'b0;
            last_gnt    <= 1'b1;
            result      <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
            done_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_reg       <= gnt1 ? a1 : a0;
                        b_reg       <= gnt1 ? b1 : b0;
                        carry       <= gnt1 ? cin1 : cin0;
                        id_reg      <= gnt1;
                        last_gnt    <= gnt1;
                        idx         <= '0;
                        result_work <= '0;
                    end
                end
                RUN: begin
                    result_work <= sum_full;
                    carry       <= add_cout;
                    idx         <= idx + IW'(1);
                    // Final slice: publish directly from the merged sum so the
                    // outputs are already valid during the DONE cycle.
                    if (last_slice) begin
                        result  <= sum_full;
                        cout    <= add_cout;
                        ovf     <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                   (sum_full[WIDTH-1] != a_reg[WIDTH-1]);
                        done_id <= id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adder_seq_arbiter.md
Name: adder_seq_arbiter

Overview:
- Shares one external SLICE-bit adder slice (4-bit carry-skip/ripple block) between two requesters.
- Performs WIDTH-bit additions by iterating the slice LSB-first, with the carry held in a register between cycles.
- Round-robin arbitration between the two requesters.
- Sits between requesting units and the slice datapath; sequences the slice operands and assembles the full-width result.

Parameters:
WIDTH, 16, operand/result width; must be an integer multiple of SLICE
SLICE, 4, width of external adder slice
NSLICE, WIDTH/SLICE, slices per operation (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request; held with operands until gnt0
a0, b0  in  WIDTH  requester 0 operands
cin0  in  1  requester 0 carry-in
req1  in  1  requester 1 request
a1, b1  in  WIDTH  requester 1 operands
cin1  in  1  requester 1 carry-in
gnt0, gnt1  out  1  grant; operands captured at the clock edge ending a cycle in which grant is high
busy  out  1  high when state != IDLE
done  out  1  one-cycle result-valid pulse
done_id  out  1  requester index of completed op
result  out  WIDTH  sum, held until next done
cout  out  1  carry out of MSB slice
ovf  out  1  two's-complement overflow
add_a, add_b  out  SLICE  slice operands to adder
add_cin  out  1  slice carry-in
add_sum  in  SLICE  slice sum (combinational from add_a/add_b/add_cin)
add_cout  in  1  slice carry-out

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx=0; carry reg=0; result=0, cout=0, ovf=0, done=0, done_id=0; gnt0=gnt1=0; add_a=add_b=0, add_cin=0; rr pointer favours req0.
- Reset mid-operation aborts the op: no done pulse, partial result discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - gnt0/gnt1 are combinational, at most one high, only in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester not granted most recently.
  - On a grant edge: capture a, b, cin and id; idx<=0; rr pointer updated; go to RUN.
  - No request: stay.
- RUN:
  - Drive add_a = a_reg[idx*SLICE +: SLICE], add_b likewise, add_cin = carry reg.
  - Each edge: result_work slice idx <= add_sum; carry <= add_cout; idx++.
  - After the edge with idx=NSLICE-1: go to DONE.
  - Exactly NSLICE cycles.
- DONE:
  - done=1 for one cycle.
  - result, cout (final carry) and done_id are valid.
  - ovf = (a_reg[MSB]==b_reg[MSB]) && (result[MSB]!=a_reg[MSB]); cin is not included in the sign test, the sum MSB is.
  - Next state IDLE unconditionally.
- Outside RUN: add_a, add_b, add_cin are driven 0.
- Latency: grant in cycle T; RUN T+1..T+NSLICE; done in T+NSLICE+1. Earliest next grant is T+NSLICE+2, so throughput is 1 op per NSLICE+2 cycles.
- Requests while busy: ignored, no grant; the requester keeps req high and operands stable.
- Requests dropped before grant: no effect.
- Operand changes after grant do not affect the op in flight.
- result/cout/ovf/done_id keep their last value between done pulses.
- Arithmetic: modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.

Test Plan:
- req0, a0=0x1234, b0=0x4321, cin0=0 at T -> gnt0 at T; add_a sequence 0x4,0x3,0x2,0x1 over T+1..T+4; done at T+5 with result=0x5555, cout=0, ovf=0, done_id=0.
- req1, a1=0xFFFF, b1=0x0001, cin1=0 -> carry ripples through all 4 slices (add_cin 0,1,1,1); result=0x0000, cout=1, ovf=0, done_id=1.
- req0, 0x7FFF+0x0001 -> result=0x8000, ovf=1, cout=0. Then 0x8000+0x8000 with cin0=1 -> result=0x0001, cout=1, ovf=1.
- req0 and req1 held continuously with distinct operands -> grants alternate 0,1,0,1, spaced 6 cycles apart. done_id matches each grant; no grant while busy=1.
- rst_n pulsed low during RUN at idx=2 -> outputs zero immediately, no done pulse; after release, both req high -> gnt0 first.
- req1 asserted during an op for req0 -> gnt1 only in the IDLE cycle after done. Changing a0 after gnt0 does not alter result.
